// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_pkg
//   Shared state encodings, stage-control bundles and hazard helpers.
//   Revision: 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // addi x0, x0, 0 -- what IF/ID consumers load when if_id_flush is high
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
    } ctrl_t;

    localparam ctrl_t c_CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t c_CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t c_CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t c_CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    function automatic logic f_load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter
//   Falling-edge counter that sticks at all-ones instead of wrapping.
//   Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl
//   Stage enable/flush/bubble sequencing for load-use, redirect and MEM waits.
//   Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_en,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [TO_W-1:0] c_WAIT_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TO_W-1:0]   r_wait_cnt;
    logic [TO_W-1:0]   w_wait_nxt;
    logic              r_mem_timeout;
    logic              w_load_use;
    logic              w_mem_busy;
    logic              w_run_rules;
    logic              w_stall_inc;
    logic              w_flush_inc;
    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;

    assign w_load_use = f_load_use(i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
                                   i_ex_rd, i_ex_mem_read);
    assign w_mem_busy = i_mem_req & ~i_mem_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_run_rules = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_ctrl      = c_CTRL_RUN;

        unique case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_ctrl      = c_CTRL_FREEZE;
                    w_stall_inc = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = TO_W'(1);
                end else begin
                    w_run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!i_mem_ready) begin
                    w_ctrl      = c_CTRL_FREEZE;
                    w_stall_inc = 1'b1;
                    w_wait_nxt  = r_wait_cnt + 1'b1;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = ST_ERROR;
                    end
                end else begin
                    // Release cycle: a redirect or load-use held in EX acts now, once
                    w_run_rules = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_ERROR: begin
                w_ctrl = c_CTRL_FREEZE;
            end
            default: begin
                w_ctrl      = c_CTRL_FREEZE;
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        if (w_run_rules) begin
            if (i_ex_taken) begin
                w_ctrl      = c_CTRL_REDIRECT;
                w_flush_inc = 1'b1;
            end else if (w_load_use) begin
                w_ctrl      = c_CTRL_LOAD_USE;
                w_stall_inc = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_state_nxt == ST_ERROR) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // While reset is held the pipe sees plain RUN controls regardless of inputs
    assign w_ctrl_out = reset ? w_ctrl : c_CTRL_RUN;

    assign o_pc_en        = w_ctrl_out.pc_en;
    assign o_if_id_en     = w_ctrl_out.if_id_en;
    assign o_if_id_flush  = w_ctrl_out.if_id_flush;
    assign o_id_ex_en     = w_ctrl_out.id_ex_en;
    assign o_id_ex_bubble = w_ctrl_out.id_ex_bubble;
    assign o_ex_mem_en    = w_ctrl_out.ex_mem_en;
    assign o_mem_timeout  = r_mem_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_stall_inc),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_flush_inc),
        .o_cnt (o_flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl
//   Two parameterisations driven in lockstep against a behavioural model.
//   Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, tk, req, rdy;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_timeout}
    wire [6:0]  ctrl_a, ctrl_b;
    wire [15:0] stall_a, flush_a;
    wire [1:0]  stall_b, flush_b;

    localparam logic [6:0] c_NORM = 7'b1101010;
    localparam logic [6:0] c_FRZ  = 7'b0000000;
    localparam logic [6:0] c_RDIR = 7'b1111110;
    localparam logic [6:0] c_LU   = 7'b0001110;
    localparam logic [6:0] c_ERR  = 7'b0000001;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(4), .TO_W(7)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
        .i_ex_rd(rd), .i_ex_mem_read(mr), .i_ex_taken(tk),
        .i_mem_req(req), .i_mem_ready(rdy),
        .o_pc_en(ctrl_a[6]), .o_if_id_en(ctrl_a[5]), .o_if_id_flush(ctrl_a[4]),
        .o_id_ex_en(ctrl_a[3]), .o_id_ex_bubble(ctrl_a[2]), .o_ex_mem_en(ctrl_a[1]),
        .o_mem_timeout(ctrl_a[0]), .o_stall_cnt(stall_a), .o_flush_cnt(flush_a)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT(64), .TO_W(7)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
        .i_ex_rd(rd), .i_ex_mem_read(mr), .i_ex_taken(tk),
        .i_mem_req(req), .i_mem_ready(rdy),
        .o_pc_en(ctrl_b[6]), .o_if_id_en(ctrl_b[5]), .o_if_id_flush(ctrl_b[4]),
        .o_id_ex_en(ctrl_b[3]), .o_id_ex_bubble(ctrl_b[2]), .o_ex_mem_en(ctrl_b[1]),
        .o_mem_timeout(ctrl_b[0]), .o_stall_cnt(stall_b), .o_flush_cnt(flush_b)
    );

    // Model: per instance, an error flag, a "waiting on memory" flag, the run
    // length of consecutive busy cycles, and the two event tallies.
    bit m_err[2]   = '{0, 0};
    bit m_wait[2]  = '{0, 0};
    int m_busyn[2] = '{0, 0};
    int m_stall[2] = '{0, 0};
    int m_flush[2] = '{0, 0};
    int c_tmo[2]   = '{4, 64};
    int c_max[2]   = '{65535, 3};

    function automatic bit f_lu();
        return mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic bit f_busy(input int i);
        return m_wait[i] ? !rdy : (req && !rdy);
    endfunction

    function automatic logic [6:0] f_exp(input int i);
        if (!reset)        return c_NORM;
        if (m_err[i])      return c_ERR;
        if (f_busy(i))     return c_FRZ;
        if (tk)            return c_RDIR;
        if (f_lu())        return c_LU;
        return c_NORM;
    endfunction

    always @(negedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_err[i] = 0; m_wait[i] = 0; m_busyn[i] = 0;
                m_stall[i] = 0; m_flush[i] = 0;
            end else if (!m_err[i]) begin
                if (f_busy(i)) begin
                    if (m_stall[i] < c_max[i]) m_stall[i]++;
                    m_busyn[i] = m_wait[i] ? m_busyn[i] + 1 : 1;
                    m_wait[i]  = 1;
                    if (m_busyn[i] == c_tmo[i]) m_err[i] = 1;
                end else begin
                    m_wait[i]  = 0;
                    m_busyn[i] = 0;
                    if (tk) begin
                        if (m_flush[i] < c_max[i]) m_flush[i]++;
                    end else if (f_lu()) begin
                        if (m_stall[i] < c_max[i]) m_stall[i]++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(posedge clk) begin
        chk("model_ctrl_a",  int'(ctrl_a),  int'(f_exp(0)));
        chk("model_stall_a", int'(stall_a), m_stall[0]);
        chk("model_flush_a", int'(flush_a), m_flush[0]);
        chk("model_ctrl_b",  int'(ctrl_b),  int'(f_exp(1)));
        chk("model_stall_b", int'(stall_b), m_stall[1]);
        chk("model_flush_b", int'(flush_b), m_flush[1]);
    end

    task automatic drv(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_rd,
                       input logic a_u1, input logic a_u2, input logic a_mr,
                       input logic a_tk, input logic a_req, input logic a_rdy);
        rs1 = a_rs1; rs2 = a_rs2; rd = a_rd;
        u1 = a_u1; u2 = a_u2; mr = a_mr; tk = a_tk; req = a_req; rdy = a_rdy;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        // Load-use pattern present during reset must not leak to the outputs
        drv(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("rst_ctrl", int'(ctrl_a), int'(c_NORM));
        chk("rst_stall", int'(stall_a), 0);
        idle();
        reset = 1'b1;

        // ex_rd = x0 and an unused rs2 both leave the pipe running
        drv(5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mid(); chk("rd0_ctrl", int'(ctrl_a), int'(c_NORM)); tick();
        drv(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mid(); chk("nouse_ctrl", int'(ctrl_a), int'(c_NORM)); tick();
        idle();
        mid(); chk("nostall_cnt", int'(stall_a), 0); tick();

        // Load x5 in EX, ID reads rs2 = x5
        drv(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mid(); chk("lu_ctrl", int'(ctrl_a), int'(c_LU)); tick();
        idle();
        mid(); chk("lu_stall", int'(stall_a), 1);
        chk("lu_after_ctrl", int'(ctrl_a), int'(c_NORM)); tick();

        // Redirect outranks load-use
        drv(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mid(); chk("tk_ctrl", int'(ctrl_a), int'(c_RDIR)); tick();
        idle();
        mid(); chk("tk_flush", int'(flush_a), 1);
        chk("tk_stall", int'(stall_a), 1); tick();

        // Three busy cycles with a taken branch parked in EX, then release
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) begin
            mid(); chk("mw_ctrl", int'(ctrl_a), int'(c_FRZ)); tick();
        end
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        mid(); chk("mw_rel_ctrl", int'(ctrl_a), int'(c_RDIR)); tick();
        idle();
        mid(); chk("mw_stall", int'(stall_a), 4);
        chk("mw_flush", int'(flush_a), 2);
        chk("mw_b_sat", int'(stall_b), 3);
        chk("mw_run_ctrl", int'(ctrl_a), int'(c_NORM)); tick();

        // Single-cycle access: no stall
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        mid(); chk("single_ctrl", int'(ctrl_a), int'(c_NORM)); tick();
        idle();
        mid(); chk("single_stall", int'(stall_a), 4); tick();

        // Memory never answers: instance A (TIMEOUT=4) errors after 4 busy cycles
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) begin mid(); tick(); end
        mid(); chk("to_pre_ctrl", int'(ctrl_a), int'(c_FRZ)); tick();
        mid(); chk("to_err_ctrl", int'(ctrl_a), int'(c_ERR));
        drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        mid(); chk("to_hold_ctrl", int'(ctrl_a), int'(c_ERR));
        chk("to_stall", int'(stall_a), 8);
        chk("to_flush", int'(flush_a), 2);
        tick();
        idle();
        #1 reset = 1'b0;
        #1 chk("rst_err_ctrl", int'(ctrl_a), int'(c_NORM));
        chk("rst_err_stall", int'(stall_a), 0);
        chk("rst_err_flush", int'(flush_a), 0);
        chk("rst_b_stall", int'(stall_b), 0);
        #1 reset = 1'b1;
        mid(); chk("post_rst_ctrl", int'(ctrl_a), int'(c_NORM)); tick();

        // Five back-to-back load-use stalls: 2-bit counter sticks at 3
        drv(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) begin mid(); tick(); end
        idle();
        mid(); chk("sat_b", int'(stall_b), 3);
        chk("sat_a", int'(stall_a), 5); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
